fifo_rd_arbiter: RTL
====================

FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 Parameter N, default 4: number of prefetch-FIFO read ports arbitrated, range 2..8.
REQ-002 Parameter DW, default 24: data width per port.
REQ-003 Parameter BURST_LEN, default 16: words per grant, range 2..256.
REQ-004 Parameter STALL_MAX, default 8: consecutive starved cycles before a burst aborts.
REQ-005 rd_clk  in  1  clock; all logic on its rising edge.
REQ-006 rd_rst  in  1  reset, asynchronous, active-high.
REQ-007 cfg_mask  in  N  1 = port excluded from arbitration.
REQ-008 src_vld  in  N  per-port prefetch-FIFO rd_vld (head word valid).
REQ-009 src_data  in  N*DW  per-port head word; port i occupies bits [i*DW +: DW].
REQ-010 src_rd_en  out  N  per-port pop strobe (FIFO rd_en); at most one bit high per cycle.
REQ-011 out_data  out  DW  merged output word.
REQ-012 out_valid  out  1  out_data valid.
REQ-013 out_ready  in  1  downstream accepts the word when out_valid is also high.
REQ-014 out_src  out  clog2(N)  index of the port that supplied out_data.
REQ-015 out_last  out  1  word completes a full BURST_LEN burst.
REQ-016 burst_abort  out  1  one-cycle pulse when a burst ends on stall timeout.

Function
REQ-017 FSM states are IDLE, ARB and BURST.
REQ-018 IDLE: go to ARB when any bit of (src_vld & ~cfg_mask) is high.
REQ-019 ARB, one cycle: grant the first eligible port searching upward, with wrap, from last_grant+1; latch grant, clear word count and stall count, then go to BURST.
REQ-020 ARB with no eligible port (requests withdrawn or masked): return to IDLE and leave last_grant unchanged.
REQ-021 BURST: src_rd_en[grant] = src_vld[grant] & (~out_valid | out_ready); all other src_rd_en bits are 0.
REQ-022 Output stage is a single register: on a pop, out_data/out_src load the granted port's word and out_valid=1 on the next cycle (latency 1).
REQ-023 out_valid clears after out_ready=1 unless a new pop occurs in the same cycle; back-to-back pops sustain 1 word/cycle.
REQ-024 out_data, out_src and out_last hold stable while out_valid=1 & out_ready=0.
REQ-025 Word count increments per pop; the pop with count = BURST_LEN-1 sets out_last on that word, and the FSM goes to IDLE with last_grant=grant.
REQ-026 Stall count increments each BURST cycle with src_vld[grant]=0, clears on any pop, and does not increment while the output is back-pressured.
REQ-027 When stall count reaches STALL_MAX: burst_abort pulses, out_last is not asserted, and the FSM goes to IDLE with last_grant=grant.
REQ-028 cfg_mask is sampled only in IDLE and ARB; masking the granted port mid-burst does not end the burst.
REQ-029 No pop occurs in IDLE or ARB; an output word pending at burst end still drains normally.
REQ-030 Word counter width is clog2(BURST_LEN)+1; stall counter width is clog2(STALL_MAX)+1; neither counter wraps.

Reset
REQ-031 On rd_rst: FSM=IDLE, last_grant=N-1 (so port 0 wins first), counters=0, out_valid=0, out_last=0, burst_abort=0, out_data=0, out_src=0, src_rd_en=0.
REQ-032 Reset mid-burst drops any pending output word without a pop and takes effect immediately (asynchronous).

Structure
REQ-033 Shared package fifo_arb_pkg holds the FSM state enum and the clog2 function.
REQ-034 Round-robin priority search is a sub-module rr_pick (inputs: request vector, last index; outputs: found flag, index), purely combinational.

Verification
REQ-035 Ports 0..3 always valid, out_ready=1 -> bursts of 16 in order 0,1,2,3,0; out_last on every 16th word; one ARB+IDLE gap between bursts.
REQ-036 Port 2 only, with 5 words then src_vld low -> 5 words out, burst_abort 8 cycles after the last pop, no out_last, next grant search starts at port 3.
REQ-037 out_ready toggled 1/0 each cycle during a burst -> no lost or duplicated words, out_data stable while stalled, and no stall timeout while back-pressured.
REQ-038 cfg_mask=4'b0101 with all ports valid -> only ports 1 and 3 are granted, alternating.
REQ-039 rd_rst asserted after 7 words of a burst -> all outputs zero immediately; after release, port 0 is granted first.
REQ-040 Scoreboard check on all tests -> src_rd_en stays one-hot-or-zero, and per-port word order matches the per-port FIFO contents.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the prefetch-FIFO read arbiter.
// Holds the arbiter FSM state encoding and a constant-foldable ceil(log2).
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArb,
        StBurst
    } arb_state_e;

    // ceil(log2(value)); callers guarantee value >= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result = 0;
        for (int unsigned rem = value - 1; rem > 0; rem = rem >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search: first set request strictly after 'last', with wrap.
// Purely combinational.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic [IW-1:0] cand;
        cand  = '0;
        found = 1'b0;
        idx   = '0;
        // Walk from the farthest candidate back so the nearest one is written last.
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Bursting round-robin merge of N prefetch-FIFO read ports into one output stream,
// with a single-entry output register and stall-timeout burst abort.
module fifo_rd_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned DW        = 24,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned STALL_MAX = 8
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [N-1:0]          cfg_mask,
    input  logic [N-1:0]          src_vld,
    input  logic [N*DW-1:0]       src_data,
    output logic [N-1:0]          src_rd_en,
    output logic [DW-1:0]         out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [clog2(N)-1:0]   out_src,
    output logic                  out_last,
    output logic                  burst_abort
);

    localparam int unsigned IW = clog2(N);
    localparam int unsigned WW = clog2(BURST_LEN) + 1;
    localparam int unsigned SW = clog2(STALL_MAX) + 1;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [DW-1:0] data_q, data_d;
    logic [IW-1:0] src_q, src_d;
    logic          valid_q, valid_d;
    logic          last_word_q, last_word_d;
    logic          abort_q, abort_d;

    logic [N-1:0]  eligible;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          held;
    logic          pop;
    logic          final_word;
    logic [DW-1:0] head;

    assign eligible = src_vld & ~cfg_mask;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req   (eligible),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        head = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == IW'(i)) begin
                head = src_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        held       = valid_q & ~out_ready;
        pop        = (state_q == StBurst) & src_vld[grant_q] & ~held;
        final_word = (wcnt_q == WW'(BURST_LEN - 1));
        src_rd_en  = '0;
        if (pop) begin
            src_rd_en[grant_q] = 1'b1;
        end
    end

    // FSM and burst counters; cfg_mask only matters through 'eligible' in Idle/Arb.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wcnt_d  = wcnt_q;
        scnt_d  = scnt_q;
        abort_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d = StArb;
                end
            end
            StArb: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    wcnt_d  = '0;
                    scnt_d  = '0;
                    state_d = StBurst;
                end else begin
                    state_d = StIdle;
                end
            end
            StBurst: begin
                if (pop) begin
                    wcnt_d = wcnt_q + WW'(1);
                    scnt_d = '0;
                    if (final_word) begin
                        state_d = StIdle;
                        last_d  = grant_q;
                    end
                end else if (!src_vld[grant_q] && !held) begin
                    // Back-pressure is not starvation, so it never advances the timeout.
                    scnt_d = scnt_q + SW'(1);
                    if (scnt_q == SW'(STALL_MAX - 1)) begin
                        abort_d = 1'b1;
                        state_d = StIdle;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d      = data_q;
        src_d       = src_q;
        valid_d     = valid_q;
        last_word_d = last_word_q;
        if (pop) begin
            data_d      = head;
            src_d       = grant_q;
            valid_d     = 1'b1;
            last_word_d = final_word;
        end else if (out_ready) begin
            valid_d     = 1'b0;
            last_word_d = 1'b0;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            last_q      <= IW'(N - 1);
            wcnt_q      <= '0;
            scnt_q      <= '0;
            data_q      <= '0;
            src_q       <= '0;
            valid_q     <= 1'b0;
            last_word_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            wcnt_q      <= wcnt_d;
            scnt_q      <= scnt_d;
            data_q      <= data_d;
            src_q       <= src_d;
            valid_q     <= valid_d;
            last_word_q <= last_word_d;
            abort_q     <= abort_d;
        end
    end

    assign out_data    = data_q;
    assign out_src     = src_q;
    assign out_valid   = valid_q;
    assign out_last    = last_word_q;
    assign burst_abort = abort_q;

endmodule
